seq_match_display: RTL
======================

SEQ_MATCH_DISPLAY -- requirements
Module: seq_match_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per display digit slot (min 2).
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, clk cycles the match LED stays lit after a match (min 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bit_valid  input  1  one-cycle strobe, one per new serial bit from the sequence detector.
REQ-006 SHALL have port match  input  1  detector compare result, sampled only when bit_valid=1.
REQ-007 SHALL have port clear  input  1  synchronous clear of both counters and the overflow flag.
REQ-008 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dig_sel  output  4  digit enables, active-low, one-hot-zero.
REQ-010 SHALL have port match_led  output  1  pulse-stretched match indicator, active-high.
REQ-011 SHALL have port match_ovf  output  1  sticky flag, match count reached saturation.

Function
REQ-012 Bit counter SHALL be 2-digit BCD and increment by 1 on every bit_valid, wrapping 99->00.
REQ-013 Match counter SHALL be 2-digit BCD and increment by 1 on every cycle with bit_valid=1 and match=1, saturating at 99.
REQ-014 Back-to-back overlapping matches SHALL each count.
REQ-015 An event at match count 99 SHALL hold 99 and set match_ovf=1 the next cycle.
REQ-016 Counter and flag updates SHALL be visible one cycle after the qualifying edge.
REQ-017 clear=1 SHALL zero both counters and match_ovf on the next edge and take priority over a simultaneous bit_valid; that bit is not counted.
REQ-018 BCD digits SHALL never hold values 10-15; ones 9 with increment SHALL give ones 0 and tens +1.
REQ-019 match_led SHALL go 1 the cycle after a counted match and stay 1 for exactly HOLD_CYCLES cycles; a new match while lit SHALL restart the full hold.
REQ-020 clear SHALL NOT affect match_led or the scan.
REQ-021 Scan prescaler SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance 0->1->2->3->0.
REQ-022 Digit mapping: 0 bit-count ones, 1 bit-count tens, 2 match ones, 3 match tens; dig_sel[i]=0 for active index i.
REQ-023 seg SHALL use C0,F9,A4,B0,99,92,82,F8,80,90 (hex) for digits 0..9, dp bit 1 (off).
REQ-024 Exception: on digit 3, dp bit SHALL equal ~match_ovf.
REQ-025 seg and dig_sel SHALL be registered and change together, one cycle after the index advances or the shown digit's value changes.

Reset
REQ-026 While rst=1: counters 00, match_ovf=0, match_led=0, hold counter 0, prescaler 0, digit index 0.
REQ-027 While rst=1: dig_sel=4'b1110, seg=8'hC0.
REQ-028 Reset asserted mid-scan or mid-hold SHALL abort immediately without waiting for clk.
REQ-029 After release, first prescaler increment SHALL occur on the first clk edge.

Structure
REQ-030 Shared package seq_disp_pkg SHALL hold the 7-segment pattern table, blank/dp constants and the digit count (4).
REQ-031 A sub-module bcd2_counter (2-digit BCD, inc/clear, wrap-or-saturate select, at_max output) SHALL be instantiated twice.
REQ-032 Segment decode, scan and hold logic SHALL live in seq_match_display.

Verification (SCAN_DIV=4, HOLD_CYCLES=8)
REQ-033 Reset then 16 clks idle -> dig_sel sequence 1110,1101,1011,0111 each held 4 cycles; seg=C0 throughout.
REQ-034 16 bit_valid strobes of 0111_0100_1101_1010 with match=1 on 16th only -> bit count 16 (digits 6,1), match count 01, match_led high exactly 8 cycles.
REQ-035 100 strobes all match=1 -> match 99, match_ovf=1, digit 3 seg=10 (9 with dp lit), bit count 00.
REQ-036 clear and bit_valid/match in same cycle -> both counters 00, match_ovf 0, match_led unaffected.
REQ-037 Matches 5 cycles apart -> match_led stays high continuously until 8 cycles after the second.
REQ-038 rst pulsed mid-hold and on digit 2 -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/seq_disp_pkg.sv
// Shared constants for the sequence-match counter display:
// 7-segment patterns, blank/dp masks and digit count.
package seq_disp_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [3:0] bcd_t;
   typedef logic [1:0] dig_idx_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DP    = 8'h80;

   // Active-low {dp,g,f,e,d,c,b,a}, dp off
   localparam logic [7:0] SEG_TABLE [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   function automatic logic [7:0] seg_of(input bcd_t d);
      logic [7:0] r;
      r = SEG_BLANK;
      for (int i = 0; i < 10; i++) begin
         if (d == 4'(i)) r = SEG_TABLE[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with clear priority and
// selectable wrap (99->00) or saturate (hold 99).
module bcd2_counter
   import seq_disp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clear,
   input  logic sat,
   output bcd_t tens,
   output bcd_t ones,
   output logic at_max
);

   assign at_max = (tens == 4'd9) && (ones == 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= '0;
         ones <= '0;
      end else if (clear) begin
         tens <= '0;
         ones <= '0;
      end else if (inc) begin
         if (at_max) begin
            if (!sat) begin
               tens <= '0;
               ones <= '0;
            end
         end else if (ones == 4'd9) begin
            ones <= '0;
            tens <= tens + 4'd1;
         end else begin
            ones <= ones + 4'd1;
         end
      end
   end

endmodule

// File: rtl/seq_match_display.sv
// Bit/match counters for a serial sequence detector with a
// multiplexed 4-digit 7-segment display and stretched match LED.
module seq_match_display
   import seq_disp_pkg::*;
#(
   parameter int SCAN_DIV    = 50000,
   parameter int HOLD_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_valid,
   input  logic       match,
   input  logic       clear,
   output logic [7:0] seg,
   output logic [3:0] dig_sel,
   output logic       match_led,
   output logic       match_ovf
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

   bcd_t            bit_tens, bit_ones;
   bcd_t            mat_tens, mat_ones;
   logic            mat_max;
   logic            match_ev;
   logic [PW-1:0]   pre;
   dig_idx_t        idx;
   logic [HW-1:0]   hold;
   bcd_t            shown;
   logic [3:0]      sel_nxt;
   logic [7:0]      seg_nxt;

   assign match_ev = bit_valid & match;

   bcd2_counter u_bit_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (bit_valid),
      .clear  (clear),
      .sat    (1'b0),
      .tens   (bit_tens),
      .ones   (bit_ones),
      .at_max ()
   );

   bcd2_counter u_match_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (match_ev),
      .clear  (clear),
      .sat    (1'b1),
      .tens   (mat_tens),
      .ones   (mat_ones),
      .at_max (mat_max)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_ovf <= 1'b0;
      end else if (clear) begin
         match_ovf <= 1'b0;
      end else if (match_ev && mat_max) begin
         match_ovf <= 1'b1;
      end
   end

   // The LED ignores clear: any match restarts the full hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= '0;
      end else if (match_ev) begin
         hold <= HOLD_LOAD;
      end else if (hold != '0) begin
         hold <= hold - 1'b1;
      end
   end

   assign match_led = (hold != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_MAX) begin
         pre <= '0;
         idx <= idx + 2'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   always_comb begin
      shown   = bit_ones;
      sel_nxt = 4'b1110;
      case (idx)
         2'd0: begin shown = bit_ones; sel_nxt = 4'b1110; end
         2'd1: begin shown = bit_tens; sel_nxt = 4'b1101; end
         2'd2: begin shown = mat_ones; sel_nxt = 4'b1011; end
         2'd3: begin shown = mat_tens; sel_nxt = 4'b0111; end
         default: ;
      endcase
      seg_nxt = seg_of(shown);
      if (idx == dig_idx_t'(NUM_DIGITS - 1)) begin
         seg_nxt[7] = ~match_ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg     <= SEG_TABLE[0];
         dig_sel <= 4'b1110;
      end else begin
         seg     <= seg_nxt;
         dig_sel <= sel_nxt;
      end
   end

endmodule
